// File: rtl/mac_accum_seq.sv
// rtl/mac_accum_seq.sv - sequencer that sums num_terms products through an external MAC stage
module mac_accum_seq #(
    parameter int a_width   = 6,
    parameter int b_width   = 8,
    parameter int out_width = 18,
    parameter int num_terms = 4
) (
    input  logic                 inst_clk,
    input  logic                 inst_rst,
    input  logic                 inst_clear,
    input  logic                 inst_in_valid,
    output logic                 inst_in_ready,
    input  logic [a_width-1:0]   inst_a,
    input  logic [b_width-1:0]   inst_b,
    input  logic                 inst_tc,
    output logic [a_width-1:0]   mac_a,
    output logic [b_width-1:0]   mac_b,
    output logic                 mac_tc,
    output logic [out_width-1:0] mac_c,
    input  logic [out_width-1:0] mac_accum,
    output logic                 inst_out_valid,
    input  logic                 inst_out_ready,
    output logic [out_width-1:0] inst_out_data
);

    localparam int cnt_w = (num_terms > 2) ? $clog2(num_terms) : 1;
    localparam logic [cnt_w-1:0] last_cnt = cnt_w'(num_terms - 1);

    typedef enum logic {
        ACC = 1'b0,
        OUT = 1'b1
    } state_t;

    state_t               state;
    logic [cnt_w-1:0]     count;
    logic [out_width-1:0] acc;
    logic                 tc_lat;
    logic                 accept;

    // Gated by inst_rst so no term can be offered while reset is held.
    assign inst_in_ready = !inst_rst && (state == ACC) && !inst_clear;
    assign accept        = inst_in_valid && inst_in_ready;

    assign mac_a  = inst_a;
    assign mac_b  = inst_b;
    assign mac_c  = (count == '0) ? '0 : acc;
    assign mac_tc = (count == '0) ? inst_tc : tc_lat;

    always_ff @(posedge inst_clk or posedge inst_rst) begin
        if (inst_rst) begin
            state          <= ACC;
            count          <= '0;
            acc            <= '0;
            tc_lat         <= 1'b0;
            inst_out_data  <= '0;
            inst_out_valid <= 1'b0;
        end else begin
            case (state)
                ACC: begin
                    if (inst_clear) begin
                        count <= '0;
                        acc   <= '0;
                    end else if (accept) begin
                        acc <= mac_accum;
                        if (count == '0) begin
                            tc_lat <= inst_tc;
                        end
                        if (count == last_cnt) begin
                            count          <= '0;
                            state          <= OUT;
                            inst_out_data  <= mac_accum;
                            inst_out_valid <= 1'b1;
                        end else begin
                            count <= count + cnt_w'(1);
                        end
                    end
                end
                OUT: begin
                    // Clear is ignored here: a finished result is always delivered.
                    if (inst_out_ready) begin
                        state          <= ACC;
                        inst_out_valid <= 1'b0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accum_seq.sv
// tb/tb_mac_accum_seq.sv - directed self-checking bench for mac_accum_seq
module tb_mac_accum_seq;

    localparam int AW = 6;
    localparam int BW = 8;
    localparam int OW = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic          tc;
    logic [AW-1:0] mac_a;
    logic [BW-1:0] mac_b;
    logic          mac_tc;
    logic [OW-1:0] mac_c;
    logic [OW-1:0] mac_accum;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // External combinational multiply-accumulate stage.
    function automatic logic [OW-1:0] mac_model(input logic [AW-1:0] ma, input logic [BW-1:0] mb,
                                                input logic mt, input logic [OW-1:0] mc);
        logic [OW-1:0] ea, eb, p;
        ea = mt ? {{(OW-AW){ma[AW-1]}}, ma} : {{(OW-AW){1'b0}}, ma};
        eb = mt ? {{(OW-BW){mb[BW-1]}}, mb} : {{(OW-BW){1'b0}}, mb};
        p  = ea * eb;
        return p + mc;
    endfunction

    assign mac_accum = mac_model(mac_a, mac_b, mac_tc, mac_c);

    mac_accum_seq #(.a_width(AW), .b_width(BW), .out_width(OW), .num_terms(4)) dut (
        .inst_clk      (clk),
        .inst_rst      (rst),
        .inst_clear    (clear),
        .inst_in_valid (in_valid),
        .inst_in_ready (in_ready),
        .inst_a        (a),
        .inst_b        (b),
        .inst_tc       (tc),
        .mac_a         (mac_a),
        .mac_b         (mac_b),
        .mac_tc        (mac_tc),
        .mac_c         (mac_c),
        .mac_accum     (mac_accum),
        .inst_out_valid(out_valid),
        .inst_out_ready(out_ready),
        .inst_out_data (out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_group(input string tag, input logic [AW-1:0] ta, input logic [BW-1:0] tb,
                             input logic [3:0] tc_vec, input logic [OW-1:0] exp);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a        = ta;
            b        = tb;
            tc       = tc_vec[i];
            #1;
            if (i == 0) chk({tag, "_mac_c_first"}, 32'(mac_c), 32'd0);
            chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
            step();
        end
        in_valid = 1'b0;
        tc       = 1'b0;
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_out_data"}, 32'(out_data), 32'(exp));
        chk({tag, "_in_ready_out"}, 32'(in_ready), 32'd0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        chk({tag, "_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        clear     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        tc        = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);
        step();

        run_group("unsigned", 6'd3, 8'd5, 4'b0000, 18'h0003C);
        consume("unsigned");

        run_group("signed", 6'h3F, 8'h02, 4'b1111, 18'h3FFF8);
        consume("signed");

        // tc drops to 0 from the third term on; the latched value must win.
        run_group("tc_mid", 6'h3F, 8'h02, 4'b0011, 18'h3FFF8);

        // Backpressure with a live offer and a clear attempt, both ignored in OUT.
        in_valid = 1'b1;
        a        = 6'd1;
        b        = 8'd1;
        clear    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_data", 32'(out_data), 32'h3FFF8);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_hs_in_ready", 32'(in_ready), 32'd0);
        step();
        out_ready = 1'b0;
        chk("bp_ready_after", 32'(in_ready), 32'd1);
        chk("bp_valid_after", 32'(out_valid), 32'd0);

        // Clear after two 7*7 terms, with a competing valid term.
        in_valid = 1'b1;
        a        = 6'd7;
        b        = 8'd7;
        step();
        step();
        chk("clr_mac_c_partial", 32'(mac_c), 32'd98);
        clear = 1'b1;
        #1;
        chk("clr_in_ready", 32'(in_ready), 32'd0);
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("clr_mac_c_zero", 32'(mac_c), 32'd0);
        run_group("after_clr", 6'd1, 8'd1, 4'b0000, 18'd4);
        consume("after_clr");

        // Asynchronous reset between edges after three of four terms.
        in_valid = 1'b1;
        a        = 6'd5;
        b        = 8'd5;
        step();
        step();
        step();
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_mac_c", 32'(mac_c), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("arst_rel_ready", 32'(in_ready), 32'd1);
        run_group("after_rst", 6'd2, 8'd2, 4'b0000, 18'd16);
        consume("after_rst");

        run_group("max_unsigned", 6'd63, 8'd255, 4'b0000, 18'h0FB04);
        consume("max_unsigned");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mac_accum_seq.md
MAC_ACCUM_SEQ -- requirements
Module: mac_accum_seq

Interface
REQ-001 SHALL have parameter a_width, default 6, width of multiplicand inst_a.
REQ-002 SHALL have parameter b_width, default 8, width of multiplier inst_b.
REQ-003 SHALL have parameter out_width, default 18, width of accumulator, MAC feedback and result.
REQ-004 SHALL have parameter num_terms, default 4, legal range 2..256, number of products summed per group.
REQ-005 SHALL have port inst_clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port inst_rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port inst_clear  input  1  synchronous abort of the current group.
REQ-008 SHALL have port inst_in_valid  input  1  operand pair present.
REQ-009 SHALL have port inst_in_ready  output  1  block accepts operand pair this cycle.
REQ-010 SHALL have port inst_a  input  a_width  multiplicand.
REQ-011 SHALL have port inst_b  input  b_width  multiplier.
REQ-012 SHALL have port inst_tc  input  1  1 = two's complement operands, 0 = unsigned; sampled on first term of a group.
REQ-013 SHALL have ports mac_a (a_width), mac_b (b_width), mac_tc (1), mac_c (out_width), all outputs, driving the external combinational multiply-accumulate stage.
REQ-014 SHALL have port mac_accum  input  out_width  combinational result mac_a*mac_b+mac_c from that stage.
REQ-015 SHALL have port inst_out_valid  output  1  group result available.
REQ-016 SHALL have port inst_out_ready  input  1  consumer takes result.
REQ-017 SHALL have port inst_out_data  output  out_width  group result.

Function
REQ-018 SHALL implement a two-state FSM: ACC (accepting terms) and OUT (holding result).
REQ-019 inst_in_ready SHALL be 1 only in ACC with inst_clear=0; a term is accepted when inst_in_valid & inst_in_ready.
REQ-020 mac_a and mac_b SHALL be combinational copies of inst_a and inst_b.
REQ-021 mac_c SHALL be 0 when term count is 0, else the accumulator register.
REQ-022 mac_tc SHALL equal inst_tc when term count is 0, else the tc value latched on the group's first accepted term.
REQ-023 On an accepted term the accumulator SHALL load mac_accum and the term count SHALL increment; arithmetic wraps modulo 2^out_width, no saturation or overflow flag.
REQ-024 On the accepted term that makes count equal num_terms, FSM SHALL go to OUT with inst_out_data = that mac_accum value, and count SHALL return to 0.
REQ-025 In OUT, inst_out_valid SHALL be 1 and inst_out_data SHALL stay stable until inst_out_valid & inst_out_ready.
REQ-026 On handshake in OUT the FSM SHALL return to ACC next cycle; no term is accepted in the handshake cycle (one bubble per group).
REQ-027 inst_clear=1 in ACC SHALL zero count and accumulator next cycle and block acceptance that cycle (clear wins over inst_in_valid).
REQ-028 inst_clear in OUT SHALL be ignored; the pending result is never discarded.
REQ-029 inst_in_valid SHALL be ignored while inst_in_ready=0; inst_tc changes mid-group SHALL have no effect.
REQ-030 Throughput in ACC SHALL be one term per cycle; result latency SHALL be one cycle after the last accepted term.

Reset
REQ-031 inst_rst=1 SHALL asynchronously force FSM=ACC, count=0, accumulator=0, latched tc=0, inst_out_data=0, inst_out_valid=0.
REQ-032 inst_in_ready SHALL be 0 while inst_rst=1 and SHALL assert the first cycle after release.
REQ-033 Reset mid-group or in OUT SHALL discard partial sum and pending result without any output handshake.

Verification
REQ-034 Unsigned group: num_terms=4, tc=0, four terms a=3,b=5 back-to-back -> out_valid one cycle after 4th accept, out_data=60 (18'h0003C).
REQ-035 Signed group: tc=1, four terms a=6'h3F (-1), b=8'h02 -> out_data=18'h3FFF8 (-8); tc toggled to 0 on term 3 -> same result.
REQ-036 Backpressure: result pending, out_ready=0 for 3 cycles -> out_valid=1, out_data stable, in_ready=0 throughout; handshake on 4th cycle -> in_ready=1 next cycle.
REQ-037 Clear: 2 terms 7*7 accepted, then inst_clear=1 with in_valid=1 -> that term not accepted; then four terms 1*1 -> out_data=4.
REQ-038 Async reset: assert inst_rst between edges after 3 of 4 terms -> all outputs zero immediately; after release, four terms 2*2 -> out_data=16.
REQ-039 Max unsigned: four terms a=63,b=255 -> out_data=64260 (18'h0FB04); bench checks mac_c=0 on first term of every group.
